// File: rtl/voice_alloc_if.sv
// Event and per-voice bus between the MIDI front end and the voice allocator.
// master: MIDI side (drives note events), slave: allocator (drives voice state).
interface voice_alloc_if #(
   parameter int VOICES = 4
);
   logic                  note_on;
   logic                  note_off;
   logic [6:0]            note_num;
   logic [6:0]            note_vel;
   logic                  busy;
   logic                  ev_drop;
   logic [VOICES-1:0]     voice_gate;
   logic [VOICES*7-1:0]   voice_note;
   logic [VOICES*7-1:0]   voice_vel;
   logic [VOICES-1:0]     voice_trig;
   logic                  voice_stolen;

   modport master (
      output note_on, note_off, note_num, note_vel,
      input  busy, ev_drop, voice_gate, voice_note,
      input  voice_vel, voice_trig, voice_stolen
   );

   modport slave (
      input  note_on, note_off, note_num, note_vel,
      output busy, ev_drop, voice_gate, voice_note,
      output voice_vel, voice_trig, voice_stolen
   );
endinterface

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: retrigger match, else lowest free, else steal oldest.
// Ports: clk, rst (async, active-high), bus (voice_alloc_if.slave).
module voice_alloc #(
   parameter int VOICES  = 4,
   parameter int VOICE_W = 2,
   parameter int AGE_W   = 8
) (
   input logic         clk,
   input logic         rst,
   voice_alloc_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      COMMIT
   } state_t;

   localparam logic [VOICE_W-1:0] LAST = VOICE_W'(VOICES - 1);

   state_t               state;
   logic [VOICE_W-1:0]   idx;

   logic                 ev_on;
   logic [6:0]           ev_num;
   logic [6:0]           ev_vel;

   logic                 match_v;
   logic [VOICE_W-1:0]   match_i;
   logic                 free_v;
   logic [VOICE_W-1:0]   free_i;
   logic                 old_v;
   logic [VOICE_W-1:0]   old_i;
   logic [AGE_W-1:0]     old_age;

   logic [VOICES-1:0]    gate_q;
   logic [VOICES-1:0]    trig_q;
   logic [6:0]           note_q [VOICES];
   logic [6:0]           vel_q  [VOICES];
   logic [AGE_W-1:0]     age_q  [VOICES];

   logic                 busy_q;
   logic                 drop_q;
   logic                 stolen_q;

   logic                 any_ev;
   logic [VOICE_W-1:0]   pick_i;
   logic                 pick_steal;
   logic [VOICES*7-1:0]  note_flat;
   logic [VOICES*7-1:0]  vel_flat;

   assign any_ev = bus.note_on | bus.note_off;

   // Free voices exist unless every voice is gated, so the oldest
   // tracker is only consulted when it is guaranteed valid.
   always_comb begin
      pick_i     = old_i;
      pick_steal = 1'b1;
      if (match_v) begin
         pick_i     = match_i;
         pick_steal = 1'b0;
      end else if (free_v) begin
         pick_i     = free_i;
         pick_steal = 1'b0;
      end
   end

   always_comb begin
      note_flat = '0;
      vel_flat  = '0;
      for (int i = 0; i < VOICES; i++) begin
         note_flat[7*i +: 7] = note_q[i];
         vel_flat[7*i +: 7]  = vel_q[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         ev_on    <= 1'b0;
         ev_num   <= '0;
         ev_vel   <= '0;
         match_v  <= 1'b0;
         match_i  <= '0;
         free_v   <= 1'b0;
         free_i   <= '0;
         old_v    <= 1'b0;
         old_i    <= '0;
         old_age  <= '0;
         gate_q   <= '0;
         trig_q   <= '0;
         busy_q   <= 1'b0;
         drop_q   <= 1'b0;
         stolen_q <= 1'b0;
         for (int i = 0; i < VOICES; i++) begin
            note_q[i] <= '0;
            vel_q[i]  <= '0;
            age_q[i]  <= '0;
         end
      end else begin
         drop_q   <= 1'b0;
         trig_q   <= '0;
         stolen_q <= 1'b0;
         case (state)
            IDLE: begin
               if (any_ev) begin
                  // A zero-velocity note_on is a note_off in MIDI.
                  ev_on   <= bus.note_on && (bus.note_vel != 7'd0);
                  ev_num  <= bus.note_num;
                  ev_vel  <= bus.note_vel;
                  drop_q  <= bus.note_on & bus.note_off;
                  idx     <= '0;
                  match_v <= 1'b0;
                  free_v  <= 1'b0;
                  old_v   <= 1'b0;
                  old_age <= '0;
                  busy_q  <= 1'b1;
                  state   <= SCAN;
               end
            end
            SCAN: begin
               if (any_ev) drop_q <= 1'b1;
               if (gate_q[idx]) begin
                  if (!match_v && note_q[idx] == ev_num) begin
                     match_v <= 1'b1;
                     match_i <= idx;
                  end
                  // Strict compare keeps the lowest index on ties.
                  if (!old_v || age_q[idx] > old_age) begin
                     old_v   <= 1'b1;
                     old_i   <= idx;
                     old_age <= age_q[idx];
                  end
               end else if (!free_v) begin
                  free_v <= 1'b1;
                  free_i <= idx;
               end
               if (idx == LAST) state <= COMMIT;
               else idx <= idx + VOICE_W'(1);
            end
            COMMIT: begin
               if (any_ev) drop_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= IDLE;
               if (ev_on) begin
                  stolen_q <= pick_steal;
                  for (int i = 0; i < VOICES; i++) begin
                     if (VOICE_W'(i) == pick_i) begin
                        gate_q[i] <= 1'b1;
                        trig_q[i] <= 1'b1;
                        note_q[i] <= ev_num;
                        vel_q[i]  <= ev_vel;
                        age_q[i]  <= '0;
                     end else if (gate_q[i] && age_q[i] != '1) begin
                        age_q[i] <= age_q[i] + AGE_W'(1);
                     end
                  end
               end else if (match_v) begin
                  // Note and velocity stay put for the release phase.
                  gate_q[match_i] <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy         = busy_q;
   assign bus.ev_drop      = drop_q;
   assign bus.voice_gate   = gate_q;
   assign bus.voice_note   = note_flat;
   assign bus.voice_vel    = vel_flat;
   assign bus.voice_trig   = trig_q;
   assign bus.voice_stolen = stolen_q;

endmodule

// File: doc/voice_alloc.md
Name: voice_alloc

Overview:
- Polyphonic voice scheduler between `midi` and a bank of VOICES wavetable oscillators.
- Accepts note-on/note-off events from `midi` and maps each note to one voice.
- Voice priority: retrigger of the same note, then lowest free voice, then steal of the oldest sounding voice.
- Drives per-voice gate/note/velocity/trigger; the synthesis bank reads these per voice.

Parameters:
- VOICES, 4, number of oscillator voices (2..16).
- VOICE_W, 2, index width, must equal clog2(VOICES).
- AGE_W, 8, width of per-voice age counter (saturating).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- note_on  input  1  one-cycle pulse: note_num/note_vel valid
- note_off  input  1  one-cycle pulse: note_num valid
- note_num  input  7  MIDI note number
- note_vel  input  7  MIDI velocity
- busy  output  1  high while an event is being processed
- ev_drop  output  1  one-cycle pulse: an event was discarded
- voice_gate  output  VOICES  per-voice gate (1 = sounding)
- voice_note  output  VOICES*7  per-voice note, voice i at [7i+6:7i]
- voice_vel  output  VOICES*7  per-voice velocity, same packing
- voice_trig  output  VOICES  one-cycle pulse: voice (re)started
- voice_stolen  output  1  one-cycle pulse, coincident with voice_trig when a sounding voice was reassigned

Behaviour:
- Reset (async, rst=1): all outputs 0; all ages 0; FSM to IDLE. A reset during SCAN/COMMIT aborts the event with no output update.
- FSM states: IDLE -> SCAN -> COMMIT -> IDLE.
- IDLE, at cycle t:
  - note_on with note_vel != 0: latch note_num/note_vel as ON.
  - note_on with note_vel == 0: treat as note_off.
  - note_off: latch as OFF.
  - On latch: go to SCAN with idx=0.
  - note_on and note_off both high: ON is taken; ev_drop pulses at t+1.
- SCAN, cycles t+1..t+VOICES, one voice per cycle, ascending idx. Tracks:
  - match: first gated voice whose note == latched note.
  - free: first voice with gate=0.
  - oldest: gated voice with the highest age; ties go to the lowest index.
- COMMIT, cycle t+VOICES+1. Registered outputs are visible from t+VOICES+2; FSM returns to IDLE at t+VOICES+2.
- ON event, voice chosen in this order:
  - match: retrigger, stolen=0.
  - else free: stolen=0.
  - else oldest: stolen=1.
- ON event, on the chosen voice k:
  - gate=1, note=latched note, vel=latched vel, age=0.
  - voice_trig[k] pulses for one cycle; voice_stolen pulses if stolen.
  - Every other gated voice: age+1, saturating at 2^AGE_W-1.
- OFF event:
  - If match found: gate of that voice cleared; its note/vel are held (release phase); age unchanged. No trig pulse.
  - If no match: no change.
- busy = 1 during cycles t+1..t+VOICES+1 (SCAN and COMMIT); 0 in IDLE.
- Any note_on/note_off arriving while busy=1 is discarded; ev_drop pulses the next cycle.
- Invariant: at most one gated voice per note number, guaranteed by the match-first rule.
- Pulse outputs (ev_drop, voice_trig, voice_stolen) are high for exactly one cycle.

Test Plan (VOICES=4):
- Reset, then note_on 60/vel 100 at cycle t:
  - busy high for t+1..t+5.
  - From t+6: voice_gate=0001, voice0 note 60 vel 100.
  - voice_trig=0001 for one cycle; voice_stolen=0.
- Notes 60,62,64,65 then 67, each sent after busy drops:
  - After the first four: gate=1111.
  - On 67: voice0 (oldest) is stolen; voice_trig=0001 and voice_stolen=1; voice0 note=67.
- Notes 60,62, then note_on 60/vel 40:
  - Voice0 retriggered; vel becomes 40; voice_trig=0001.
  - gate stays 0011; voice1 age becomes 1.
- Notes 60,62, then note_off 60:
  - gate becomes 0010; voice0 note stays 60.
  - Next note_on 70 lands in voice0 (lowest free), not voice2.
- note_on 72 vel 0:
  - Behaves as note_off; no gate set; no trig.
- Back-to-back events:
  - note_on 60 then note_on 61 one cycle later: second event dropped, ev_drop pulses once; only voice0 gated.
  - Simultaneous note_on/note_off: ON processed and ev_drop pulses.
  - Assert rst in the middle of SCAN: all outputs immediately 0.
